serial_link_arbiter: RTL and testbench
======================================

# serial_link_arbiter

Round-robin scheduler that shares the single serial transmit link feeding the 4×4-bit serial-to-parallel receiver among four parallel requesters. Each requester presents a 16-bit payload (four nibbles, A..D). The block grants the link, fires the `transmit` start strobe, and shifts the 16 bits out on `data_TX`. It then waits for the receiver's completion acknowledge, or times out, and reports back to the granted requester.

## Interface
- `TIMEOUT`, default 64: maximum cycles spent in WAIT_ACK before the transfer is abandoned; legal range 1..255.
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `clr_n`  in  1  asynchronous, active-low reset.
- `req`  in  4  request lines, bit i = requester i; level-sensitive.
- `payload`  in  64  flat payload bus; requester i owns `payload[16i+15:16i]`, bits [15:12]=A, [11:8]=B, [7:4]=C, [3:0]=D.
- `link_ack_n`  in  1  receiver completion acknowledge, active-low, synchronous to `clk`.
- `gnt`  out  4  one-hot grant; held from START through the done cycle.
- `transmit`  out  1  one-cycle start strobe to the receiver.
- `data_TX`  out  1  serial data, MSB first.
- `done`  out  4  one-cycle completion pulse to the granted requester.
- `err`  out  4  one-cycle error flag, coincident with `done`, set only on timeout.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, START, SHIFT, WAIT_ACK, DONE.
- IDLE: when any `req` bit is set, select the winner by round-robin, starting at priority pointer `ptr`. Latch the winner's 16-bit payload into a shift register, then go to START. With `req`=0, remain in IDLE.
- START: `transmit`=1 and `gnt[win]`=1 for exactly one cycle; the bit counter is cleared; go to SHIFT.
- SHIFT: 16 cycles. `data_TX` presents shift-register bit 15, and the register shifts left once per cycle. Bit order is A[3]..A[0], B[3..0], C[3..0], D[3..0]. After the 16th bit, go to WAIT_ACK.
- WAIT_ACK: `data_TX`=0; the timeout counter increments each cycle.
  - If `link_ack_n`=0 is sampled, go to DONE with err=0.
  - If the counter reaches TIMEOUT first, go to DONE with err=1.
  - If both occur on the same edge, ack wins (err=0).
- DONE: `done[win]`=1 for one cycle and `err[win]` as recorded; `gnt` is still asserted this cycle. Then `ptr` ← (win+1) mod 4, and the block returns to IDLE.
- Requester rules:
  - The requester must drop `req` during its DONE cycle. If `req` is still high in IDLE, it is re-arbitrated normally and gets no priority boost.
  - `req` deassertion after the grant is ignored; the transfer completes.
  - `payload` changes after the latch are ignored.
- `link_ack_n` is ignored outside WAIT_ACK, including an early ack during SHIFT.
- Reset (at any time, including mid-SHIFT):
  - state=IDLE, `ptr`=0, counters=0, shift register=0.
  - All outputs 0: `gnt`=0, `transmit`=0, `data_TX`=0, `done`=0, `err`=0, `busy`=0.
  - An interrupted transfer is not reported through `done` or `err`.

## Timing
- All outputs are registered; none is combinational from an input.
- Let E0 be the edge that samples `req`≠0 in IDLE.
  - After E0: START (`transmit`, `gnt`, `busy` high).
  - After E1..E16: `data_TX` = payload bit 15..0.
  - After E17: WAIT_ACK.
- Ack sampled at edge Ea produces the `done` pulse after Ea. IDLE follows after Ea+1. Best-case request-to-done latency is 18 cycles.
- Timeout: `done`+`err` are asserted after the TIMEOUT-th WAIT_ACK edge without ack.
- A new START can occur no earlier than 2 cycles after a DONE (IDLE, then arbitration).
- Round-robin starting at `ptr`=p checks p, p+1, p+2, p+3 (mod 4); the first set bit wins.

## Test plan
- After reset, `req`=0001 with payload0=16'hA5C3 and `link_ack_n` pulsed low 3 cycles after the last bit.
  - `transmit` is a single pulse.
  - `data_TX` carries 1010_0101_1100_0011.
  - `done`=0001 with `err`=0000.
  - `gnt` is high for exactly 21 cycles.
- `req`=1111 held, each requester dropping `req` on its own `done`, ack returned each time: grants occur in order 0001, 0010, 0100, 1000.
- `req`=0101 with ack always returned, and requester 0 re-requesting immediately: grants alternate 0001, 0100, 0001, 0100.
- `link_ack_n` held high with TIMEOUT=64:
  - `done`=`err`=one-hot for the winner, 64 cycles after WAIT_ACK entry.
  - The next request is then served normally.
- Edge cases:
  - Assert `clr_n`=0 at SHIFT bit 7: all outputs 0 immediately, and the next grant goes to requester 0.
  - `link_ack_n` low during SHIFT is ignored; the block still waits for ack in WAIT_ACK.
  - Ack on the timeout edge gives `err`=0.

Source files
------------

// File: rtl/serial_link_arbiter.sv
// serial_link_arbiter
//   Round-robin scheduler sharing one serial transmit link among four
//   requesters. The winner's 16-bit payload is latched, a one-cycle
//   `transmit` strobe is fired, and the bits are shifted out MSB first on
//   `data_TX`. The block then waits for the receiver's active-low
//   acknowledge, or gives up after TIMEOUT cycles. It reports the outcome
//   to the granted requester with `done`, plus `err` on a timeout.
//
// Ports
//   clk         system clock, rising-edge active
//   clr_n       asynchronous active-low reset
//   req[3:0]    level-sensitive request lines, bit i = requester i
//   payload     flat bus, requester i owns payload[16i+15:16i]
//   link_ack_n  receiver completion acknowledge (active low, sync to clk)
//   gnt[3:0]    one-hot grant, held from START through DONE
//   transmit    one-cycle start strobe to the receiver
//   data_TX     serial data, MSB first
//   done[3:0]   one-cycle completion pulse to the granted requester
//   err[3:0]    one-cycle timeout flag, coincident with done
//   busy        high whenever the FSM is not idle
//
// Every output is a flop. It is loaded from the next-state decode, so no
// output has a combinational path from an input.
module serial_link_arbiter #(
  parameter int unsigned TIMEOUT = 64  // legal range 1..255
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [3:0]  req,
  input  logic [63:0] payload,
  input  logic        link_ack_n,
  output logic [3:0]  gnt,
  output logic        transmit,
  output logic        data_TX,
  output logic [3:0]  done,
  output logic [3:0]  err,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, START, SHIFT, WAIT_ACK, DONE} state_t;

  state_t      state, state_d;
  logic [1:0]  ptr, ptr_d;
  logic [1:0]  win, win_d;
  logic [15:0] sr, sr_d;
  logic [3:0]  bit_cnt, bit_cnt_d;
  logic [7:0]  to_cnt, to_cnt_d;

  logic [3:0]  gnt_d, done_d, err_d;
  logic        transmit_d, data_d, busy_d, timed_out;

  logic [1:0]  rr_win, cand;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    return 4'b0001 << idx;
  endfunction

  // Round-robin pick. The loop scans from the lowest priority offset to the
  // highest, so the last hit is the requester nearest to ptr.
  always_comb begin
    rr_win = ptr;
    cand   = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (req[cand]) rr_win = cand;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d    = state;
    ptr_d      = ptr;
    win_d      = win;
    sr_d       = sr;
    bit_cnt_d  = bit_cnt;
    to_cnt_d   = to_cnt;
    data_d     = 1'b0;
    timed_out  = 1'b0;

    unique case (state)
      IDLE: begin
        if (|req) begin
          state_d   = START;
          win_d     = rr_win;
          sr_d      = payload[{rr_win, 4'b0000} +: 16];
          bit_cnt_d = '0;
          to_cnt_d  = '0;
        end
      end
      START: begin
        // The first bit leaves on the START->SHIFT edge.
        state_d   = SHIFT;
        data_d    = sr[15];
        sr_d      = {sr[14:0], 1'b0};
        bit_cnt_d = '0;
      end
      SHIFT: begin
        // bit_cnt counts the bits already presented, minus one.
        if (bit_cnt == 4'd15) begin
          state_d  = WAIT_ACK;
          to_cnt_d = '0;
        end else begin
          data_d    = sr[15];
          sr_d      = {sr[14:0], 1'b0};
          bit_cnt_d = bit_cnt + 4'd1;
        end
      end
      WAIT_ACK: begin
        // An ack that arrives on the timeout edge still counts as success.
        if (!link_ack_n) begin
          state_d = DONE;
        end else if (to_cnt == 8'(TIMEOUT - 1)) begin
          state_d   = DONE;
          timed_out = 1'b1;
        end else begin
          to_cnt_d = to_cnt + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = win + 2'd1;
      end
      default: state_d = IDLE;
    endcase

    gnt_d      = (state_d != IDLE) ? onehot(win_d) : 4'b0000;
    transmit_d = (state_d == START);
    done_d     = (state_d == DONE) ? onehot(win_d) : 4'b0000;
    err_d      = timed_out ? onehot(win_d) : 4'b0000;
    busy_d     = (state_d != IDLE);
  end

  // NOTE: state and output flops use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge clr_n) begin
    // NOTE: the shift register is cleared on reset along with the control
    // state, so a transfer cut short by reset leaves no stale payload bits.
    if (!clr_n) begin
      state    <= IDLE;
      ptr      <= '0;
      win      <= '0;
      sr       <= '0;
      bit_cnt  <= '0;
      to_cnt   <= '0;
      gnt      <= '0;
      transmit <= 1'b0;
      data_TX  <= 1'b0;
      done     <= '0;
      err      <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      win      <= win_d;
      sr       <= sr_d;
      bit_cnt  <= bit_cnt_d;
      to_cnt   <= to_cnt_d;
      gnt      <= gnt_d;
      transmit <= transmit_d;
      data_TX  <= data_d;
      done     <= done_d;
      err      <= err_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_serial_link_arbiter.sv
// Testbench for serial_link_arbiter. The stimulus process drives requests
// and acknowledges, and for each transfer it pushes the expected grant,
// error, serial word and grant length into a scoreboard queue. A monitor
// process rebuilds the serial word from data_TX and, on every done pulse,
// pops one entry and compares it with what the DUT presented.
module tb_serial_link_arbiter;

  localparam int unsigned TO = 64;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [3:0]  req;
  logic [63:0] payload;
  logic        link_ack_n;
  logic [3:0]  gnt, done, err;
  logic        transmit, data_TX, busy;

  serial_link_arbiter #(.TIMEOUT(TO)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .req        (req),
    .payload    (payload),
    .link_ack_n (link_ack_n),
    .gnt        (gnt),
    .transmit   (transmit),
    .data_TX    (data_TX),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  gnt;
    logic [3:0]  err;
    logic [15:0] data;
    int          len;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [15:0] p [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic [3:0] e, input logic [15:0] d, input int len);
    exp_t x;
    x.gnt = g; x.err = e; x.data = d; x.len = len;
    sb.push_back(x);
  endtask

  task automatic set_payload();
    payload = {p[3], p[2], p[1], p[0]};
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_gnt"},      32'(gnt),      32'd0);
    check({tag, "_transmit"}, 32'(transmit), 32'd0);
    check({tag, "_data_TX"},  32'(data_TX),  32'd0);
    check({tag, "_done"},     32'(done),     32'd0);
    check({tag, "_err"},      32'(err),      32'd0);
    check({tag, "_busy"},     32'(busy),     32'd0);
  endtask

  // Waits, at negedges, for the transmit strobe. Bounded.
  task automatic wait_transmit(output bit seen);
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (transmit) seen = 1'b1;
    end
    check("transmit_seen", 32'(seen), 32'd1);
  endtask

  // One transfer. w = WAIT_ACK cycles before ack is sampled (or the
  // timeout length when ack=0); early = SHIFT cycle (1..16) at which a
  // stray one-cycle ack pulse is driven, 0 for none.
  // done_act: 0 keep req, 1 drop the winner's req bit, 2 clear all req.
  task automatic do_xfer(input int w, input bit ack, input int early, input int done_act);
    bit seen;
    bit got_done;
    wait_transmit(seen);
    if (seen) begin
      for (int j = 1; j <= 16 + w + 1; j++) begin
        @(negedge clk);
        link_ack_n = 1'b1;
        if (early != 0 && j == early) link_ack_n = 1'b0;
        if (ack && j == 16 + w) link_ack_n = 1'b0;
      end
      got_done = (done != 4'b0000);
      for (int k = 0; k < 10 && !got_done; k++) begin
        @(negedge clk);
        got_done = (done != 4'b0000);
      end
      check("done_seen", 32'(got_done), 32'd1);
      if (done_act == 1) req = req & ~done;
      if (done_act == 2) req = 4'b0000;
    end
  endtask

  // Monitor: rebuilds the serial word and scores each done pulse.
  initial begin
    logic [15:0] word;
    int  bit_idx;
    int  gnt_len;
    bit  capturing, check_idle, prev_tx;
    exp_t e;
    word = '0; bit_idx = 0; gnt_len = 0;
    capturing = 0; check_idle = 0; prev_tx = 0;
    forever begin
      @(negedge clk);
      if (!clr_n) begin
        capturing = 0; check_idle = 0; prev_tx = 0; gnt_len = 0;
      end else begin
        if (gnt != 4'b0000) gnt_len++;
        if (prev_tx) check("transmit_single_pulse", 32'(transmit), 32'd0);
        if (check_idle) begin
          check("data_TX_zero_in_wait", 32'(data_TX), 32'd0);
          check_idle = 0;
        end
        if (transmit) begin
          word = '0; bit_idx = 0; capturing = 1; gnt_len = 1;
        end else if (capturing) begin
          word = {word[14:0], data_TX};
          bit_idx++;
          if (bit_idx == 16) begin
            capturing  = 0;
            check_idle = 1;
          end
        end
        if (done != 4'b0000) begin
          check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("done_onehot", 32'(done),    32'(e.gnt));
            check("gnt_in_done", 32'(gnt),     32'(e.gnt));
            check("err",         32'(err),     32'(e.err));
            check("serial_word", 32'(word),    32'(e.data));
            check("gnt_cycles",  32'(gnt_len), 32'(e.len));
            check("busy_in_done", 32'(busy),   32'd1);
          end
          gnt_len = 0;
        end
        prev_tx = transmit;
      end
    end
  end

  // Stimulus
  initial begin
    bit seen;
    clr_n = 1'b0; req = 4'b0000; link_ack_n = 1'b1;
    p[0] = 16'h0000; p[1] = 16'h0000; p[2] = 16'h0000; p[3] = 16'h0000;
    set_payload();
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    clr_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("idle");

    // All four requesting, each dropping on its own done: 0,1,2,3.
    p[0] = 16'h1234; p[1] = 16'hBEEF; p[2] = 16'h0F0F; p[3] = 16'h8001;
    set_payload();
    req = 4'b1111;
    push(4'b0001, 4'b0000, 16'h1234, 19); do_xfer(1, 1, 0, 1);
    push(4'b0010, 4'b0000, 16'hBEEF, 20); do_xfer(2, 1, 0, 1);
    push(4'b0100, 4'b0000, 16'h0F0F, 19); do_xfer(1, 1, 0, 1);
    push(4'b1000, 4'b0000, 16'h8001, 22); do_xfer(4, 1, 0, 1);

    // 0101 held: requester 0 re-requests at once, grants alternate 0,2.
    p[0] = 16'hC001; p[2] = 16'h5A5A;
    set_payload();
    @(negedge clk);
    req = 4'b0101;
    push(4'b0001, 4'b0000, 16'hC001, 19); do_xfer(1, 1, 0, 0);
    push(4'b0100, 4'b0000, 16'h5A5A, 19); do_xfer(1, 1, 0, 0);
    push(4'b0001, 4'b0000, 16'hC001, 19); do_xfer(1, 1, 0, 0);
    push(4'b0100, 4'b0000, 16'h5A5A, 19); do_xfer(1, 1, 0, 2);

    // Single request, A5C3, ack three cycles after the last bit; payload
    // changes after the latch must not affect the serial word.
    @(negedge clk);
    p[0] = 16'hA5C3; set_payload();
    req = 4'b0001;
    push(4'b0001, 4'b0000, 16'hA5C3, 21);
    wait_transmit(seen);
    p[0] = 16'hFFFF; set_payload();
    req = 4'b0000;
    if (seen) begin
      for (int j = 1; j <= 20; j++) begin
        @(negedge clk);
        link_ack_n = (j == 19) ? 1'b0 : 1'b1;
      end
    end
    check("a5c3_done", 32'(done), 32'h1);
    check("a5c3_err",  32'(err),  32'h0);

    // Reset at SHIFT bit 7 of a transfer to requester 3, then 1001 must go
    // to requester 0 because the pointer is back at 0.
    @(negedge clk);
    p[3] = 16'h7E81; set_payload();
    req = 4'b1000;
    wait_transmit(seen);
    repeat (9) @(negedge clk);
    clr_n = 1'b0;
    req   = 4'b0000;
    #1;
    check_outputs_zero("midshift_reset");
    repeat (2) @(negedge clk);
    clr_n = 1'b1;
    repeat (2) @(negedge clk);
    check("no_done_after_reset", 32'(done), 32'd0);
    p[0] = 16'h6B2D; set_payload();
    req = 4'b1001;
    push(4'b0001, 4'b0000, 16'h6B2D, 20); do_xfer(2, 1, 0, 2);

    // Timeout: requester 2, ack never returned.
    @(negedge clk);
    p[2] = 16'h3C96; set_payload();
    req = 4'b0100;
    push(4'b0100, 4'b0100, 16'h3C96, 18 + TO); do_xfer(TO, 0, 0, 2);

    // The next request is served normally.
    @(negedge clk);
    p[3] = 16'hD00D; set_payload();
    req = 4'b1000;
    push(4'b1000, 4'b0000, 16'hD00D, 20); do_xfer(2, 1, 0, 2);

    // Stray ack during SHIFT is ignored; the real ack comes 5 cycles later.
    @(negedge clk);
    p[0] = 16'h4711; set_payload();
    req = 4'b0001;
    push(4'b0001, 4'b0000, 16'h4711, 23); do_xfer(5, 1, 6, 2);

    // Ack sampled on the timeout edge wins: err stays 0.
    @(negedge clk);
    p[1] = 16'h9E37; set_payload();
    req = 4'b0010;
    push(4'b0010, 4'b0000, 16'h9E37, 18 + TO); do_xfer(TO, 1, 0, 2);

    repeat (5) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
